// File: rtl/demux_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : demux_stream                                                 |
// | Description : Registered 1-to-N stream demux, one entry per channel with   |
// |               valid/ready; out-of-range selects are dropped and flagged.   |
// |               Define DEMUX_COUNT_EN for saturating per-channel counters.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module demux_stream #(
    parameter int WIDTH = 8,
    parameter int N     = 16,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SELW-1:0]    in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic               drop
`ifdef DEMUX_COUNT_EN
    ,
    input  logic [SELW-1:0]    cnt_sel,
    output logic [15:0]        cnt_out
`endif
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } chan_state_t;

    localparam logic [SELW:0] c_NUM_CH = (SELW+1)'(N);

    chan_state_t        r_state     [N];
    chan_state_t        w_state_nxt [N];
    logic [N*WIDTH-1:0] r_data;
    logic [N-1:0]       w_load;
    logic               w_in_range;
    logic               w_sel_ready;
    logic               w_accept;
    logic               r_drop;

    assign w_in_range = ({1'b0, in_sel} < c_NUM_CH);

    always_comb begin
        w_sel_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (in_sel == SELW'(k)) begin
                w_sel_ready = (r_state[k] == ST_EMPTY) || out_ready[k];
            end
        end
    end

    // Out-of-range beats are always taken so they can be discarded.
    assign in_ready = !rst && (!w_in_range || w_sel_ready);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            w_load[k]      = w_accept && (in_sel == SELW'(k));
            w_state_nxt[k] = r_state[k];
            case (r_state[k])
                ST_EMPTY: if (w_load[k])                   w_state_nxt[k] = ST_FULL;
                ST_FULL:  if (!w_load[k] && out_ready[k])  w_state_nxt[k] = ST_EMPTY;
                default:                                   w_state_nxt[k] = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst) r_state[k] <= ST_EMPTY;
            else     r_state[k] <= w_state_nxt[k];
        end
    end

    // Data is only written on a load, so an empty channel keeps its last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (w_load[k]) r_data[k*WIDTH +: WIDTH] <= in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_drop <= 1'b0;
        else     r_drop <= w_accept && !w_in_range;
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            out_valid[k] = (r_state[k] == ST_FULL);
        end
    end

    assign out_data = r_data;
    assign drop     = r_drop;

`ifdef DEMUX_COUNT_EN
    logic [15:0] r_cnt [N];

    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                r_cnt[k] <= 16'd0;
            end else if (out_valid[k] && out_ready[k] && (r_cnt[k] != 16'hFFFF)) begin
                r_cnt[k] <= r_cnt[k] + 16'd1;
            end
        end
    end

    always_comb begin
        cnt_out = 16'd0;
        for (int k = 0; k < N; k++) begin
            if (cnt_sel == SELW'(k)) cnt_out = r_cnt[k];
        end
    end
`endif

endmodule
`default_nettype wire
